teclado_notas: RTL and testbench
================================

Name: teclado_notas

Overview:
- Front-end stage that feeds the note-display decoder (`Tom`, `notas1..3` → seven segments).
- Converts eight raw note push-buttons plus a sharp/tone switch into a debounced, priority-encoded, held note code.
- Drives the decoder's inputs directly, with the same bit meaning: `notas3` MSB, `notas1` LSB, `tom` selects the tone variant.
- Adds a one-cycle `novo` pulse and an `ativo` level for downstream sequencing and sound logic.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable clock cycles required to accept a press or a release; legal range ≥1.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers; legal range ≥2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- teclas  input  8  raw asynchronous note buttons, active-high; bit i = note i.
- tecla_tom  input  1  raw asynchronous tone/sharp switch, active-high.
- tom  output  1  registered tone bit for the decoder.
- notas3  output  1  note code bit 2 (MSB).
- notas2  output  1  note code bit 1.
- notas1  output  1  note code bit 0 (LSB).
- novo  output  1  one-cycle pulse when a new note is accepted.
- ativo  output  1  high while an accepted key is considered held.

Behaviour:
- Reset (async assert, sync-free release):
  - `tom`, `notas3..1`, `novo`, `ativo` = 0.
  - All synchronizer flops = 0; state = IDLE; counter = 0; candidate = 0.
- Synchronization: `teclas` and `tecla_tom` each pass through SYNC_STAGES flops. All logic below uses only the synced values `ts` (8b) and `tt`.
- Counter: width `$clog2(DEBOUNCE_CYCLES+1)`; never wraps, because it is cleared on every state entry.
- FSM states: IDLE, FILTRO, SEGURA, SOLTA.
- IDLE:
  - `ts == 0` → stay.
  - Otherwise → FILTRO; candidate ← `ts`; counter ← 0.
- FILTRO:
  - `ts == 0` → IDLE (bounce rejected, no output change).
  - `ts != candidate` and nonzero → candidate ← `ts`, counter ← 0, stay (restart filter).
  - `ts == candidate` and counter < DEBOUNCE_CYCLES-1 → counter++.
  - `ts == candidate` and counter == DEBOUNCE_CYCLES-1 → accept:
    - `{notas3,notas2,notas1}` ← index of lowest set bit of candidate.
    - `tom` ← `tt`.
    - `novo` = 1 for that cycle only.
    - → SEGURA.
- SEGURA:
  - `ativo` = 1.
  - `ts != 0` → stay; changes to `ts` or `tt` are ignored (no re-encode while held).
  - `ts == 0` → SOLTA; counter ← 0.
- SOLTA:
  - `ativo` = 1.
  - `ts != 0` → SEGURA (release bounce, no new `novo`).
  - `ts == 0` and counter < DEBOUNCE_CYCLES-1 → counter++.
  - counter == DEBOUNCE_CYCLES-1 → IDLE; `ativo` drops on entry to IDLE.
- Latency: number the first rising edge that samples a stable press as edge 0. Outputs and `novo` update at edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Outputs `tom`/`notas` hold the last accepted value indefinitely, including through IDLE. They change only at accept or reset.
- Priority: with several keys pressed, the lowest index wins. The candidate is the whole vector, so adding or removing a key during FILTRO restarts the filter.
- `tecla_tom` alone (no note key) causes no state change.
- Reset asserted mid-filter or mid-hold returns immediately to reset values; no `novo` is generated on release of reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package `notas_pkg`:
  - State enum `estado_t` (IDLE, FILTRO, SEGURA, SOLTA).
  - Note-code constants `NOTA_DO`=0 … `NOTA_DO_AGUDO`=7.
  - `NOTA_W`=3.
- One sub-module, `sincronizador`: a parameterised width × SYNC_STAGES flop chain with async active-low reset, instantiated once for the 9 input bits.
- The priority encoder stays inline as a function.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Clean press: `teclas`=8'b0000_0100, `tecla_tom`=0, held 20 cycles → at edge 6, `notas3..1`=010, `tom`=0, `novo`=1 for exactly 1 cycle, `ativo`=1. After release, `ativo` falls 2+4+1 edges later and `notas` stay 010.
- Bouncy press: `teclas` bit 5 toggles 1,0,1,0 each cycle, then stays 1 → no `novo` during toggling; one `novo` with code 101 exactly 6 edges after the last toggle.
- Multi-key priority with tone: `teclas`=8'b1001_0000, `tecla_tom`=1 → code 100, `tom`=1. A bit 0 press added while in SEGURA is ignored (code stays 100, no `novo`).
- Release bounce: after accept, `teclas` goes 0 for 2 cycles then back to bit 3 → `ativo` stays 1, no second `novo`. A full 4-cycle release followed by a new press of bit 3 → a second `novo`.
- Reset mid-operation: assert `rst_n`=0 during FILTRO and again during SEGURA → outputs go to 0 asynchronously (before the next clock edge). After release of reset with a key still held, a full 6-edge debounce is required before `novo`.
- Sweep: press each key 0..7 with `tom`=0 then `tom`=1 sequentially → `{tom,notas3,notas2,notas1}` = 0000…1111 in order, matching the decoder's full input space.

Source files
------------

// File: rtl/teclado_notas_pkg.sv
// notas_pkg: shared types and note-code constants for the keyboard front-end.
//   estado_t  : debounce FSM states
//   NOTA_*    : 3-bit note codes driven onto {notas3,notas2,notas1}
package notas_pkg;
  typedef enum logic [1:0] {IDLE, FILTRO, SEGURA, SOLTA} estado_t;
  localparam int NOTA_W = 3;
  localparam logic [NOTA_W-1:0] NOTA_DO        = 3'd0;
  localparam logic [NOTA_W-1:0] NOTA_RE        = 3'd1;
  localparam logic [NOTA_W-1:0] NOTA_MI        = 3'd2;
  localparam logic [NOTA_W-1:0] NOTA_FA        = 3'd3;
  localparam logic [NOTA_W-1:0] NOTA_SOL       = 3'd4;
  localparam logic [NOTA_W-1:0] NOTA_LA        = 3'd5;
  localparam logic [NOTA_W-1:0] NOTA_SI        = 3'd6;
  localparam logic [NOTA_W-1:0] NOTA_DO_AGUDO  = 3'd7;
endpackage

// File: rtl/teclado_notas_if.sv
// teclado_notas_if: button inputs and decoder-side outputs of the keyboard front-end.
//   teclas[7:0], tecla_tom : raw buttons (driven by master)
//   tom, notas3..1         : held note code for the seven-segment decoder
//   novo, ativo            : new-note pulse and key-held level
interface teclado_notas_if;
  logic [7:0] teclas;
  logic       tecla_tom;
  logic       tom;
  logic       notas3;
  logic       notas2;
  logic       notas1;
  logic       novo;
  logic       ativo;
  modport master (output teclas, tecla_tom, input tom, notas3, notas2, notas1, novo, ativo);
  modport slave  (input teclas, tecla_tom, output tom, notas3, notas2, notas1, novo, ativo);
endinterface

// File: rtl/sincronizador.sv
// sincronizador: W-bit wide, STAGES-deep flop chain for asynchronous inputs.
//   clk, rst_n : clock, async active-low reset (chain clears to 0)
//   d          : raw asynchronous input
//   q          : synchronized output, STAGES cycles later
module sincronizador #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] cadeia;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cadeia <= '0;
    else cadeia <= {cadeia[STAGES-2:0], d};
  assign q = cadeia[STAGES-1];
endmodule

// File: rtl/teclado_notas.sv
// teclado_notas: debounced, priority-encoded, held note code for the note-display decoder.
//   clk, rst_n : clock, async active-low reset
//   bus        : teclado_notas_if.slave (buttons in; tom, notas3..1, novo, ativo out)
module teclado_notas
  import notas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  teclado_notas_if.slave  bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(DEBOUNCE_CYCLES - 1);
  logic [8:0]        sinc;
  logic [7:0]        ts;
  logic              tt;
  estado_t           estado;
  logic [CW-1:0]     cont;
  logic [7:0]        cand;
  logic [NOTA_W-1:0] nota;
  logic              tom;
  logic              novo;
  logic              ativo;
  sincronizador #(.W(9), .STAGES(SYNC_STAGES)) u_sinc (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({bus.tecla_tom, bus.teclas}),
    .q     (sinc)
  );
  assign {tt, ts} = sinc;
  // Lowest-index key wins.
  function automatic logic [NOTA_W-1:0] prioridade(input logic [7:0] v);
    prioridade = NOTA_DO;
    for (int i = 7; i >= 0; i--)
      if (v[i]) prioridade = NOTA_W'(i);
  endfunction
  // The whole key vector is the candidate, so any change while filtering restarts it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      estado <= IDLE;
      cont   <= '0;
      cand   <= '0;
      nota   <= '0;
      tom    <= 1'b0;
      novo   <= 1'b0;
      ativo  <= 1'b0;
    end else begin
      novo <= 1'b0;
      case (estado)
        IDLE:
          if (ts != '0) begin
            estado <= FILTRO;
            cand   <= ts;
            cont   <= '0;
          end
        FILTRO:
          if (ts == '0) estado <= IDLE;
          else if (ts != cand) begin
            cand <= ts;
            cont <= '0;
          end else if (cont != ULTIMO) cont <= cont + CW'(1);
          else begin
            nota   <= prioridade(cand);
            tom    <= tt;
            novo   <= 1'b1;
            ativo  <= 1'b1;
            estado <= SEGURA;
          end
        SEGURA:
          if (ts == '0) begin
            estado <= SOLTA;
            cont   <= '0;
          end
        SOLTA:
          if (ts != '0) estado <= SEGURA;
          else if (cont != ULTIMO) cont <= cont + CW'(1);
          else begin
            estado <= IDLE;
            ativo  <= 1'b0;
          end
        default: estado <= IDLE;
      endcase
    end
  assign bus.tom = tom;
  assign {bus.notas3, bus.notas2, bus.notas1} = nota;
  assign bus.novo  = novo;
  assign bus.ativo = ativo;
endmodule

// File: tb/tb_teclado_notas.sv
// tb_teclado_notas: directed self-checking bench for teclado_notas (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_teclado_notas;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  teclado_notas_if bus ();
  teclado_notas #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] codigo();
    return {bus.tom, bus.notas3, bus.notas2, bus.notas1};
  endfunction
  task automatic solta_tudo();
    bus.teclas = 8'h00;
    tick(8);
  endtask
  // Inputs were just changed; accept must land on edge 6 with a single-cycle novo.
  task automatic espera_aceite(input string tag, input logic [3:0] exp);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk({tag, "_sem_novo"}, bus.novo, 1'b0);
    end
    tick(1);
    chk({tag, "_novo"}, bus.novo, 1'b1);
    chk({tag, "_codigo"}, codigo(), exp);
    chk({tag, "_ativo"}, bus.ativo, 1'b1);
    tick(1);
    chk({tag, "_novo_1ciclo"}, bus.novo, 1'b0);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.teclas = 8'h00;
    bus.tecla_tom = 1'b0;
    tick(3);
    chk("reset_saidas", {codigo(), bus.novo, bus.ativo}, 6'b0);
    rst_n = 1'b1;
    tick(2);
    bus.tecla_tom = 1'b1;
    tick(8);
    chk("so_tom_sem_efeito", {codigo(), bus.novo, bus.ativo}, 6'b0);
    bus.tecla_tom = 1'b0;
    tick(4);
    // Clean press of note 2, held then released.
    bus.teclas = 8'b0000_0100;
    espera_aceite("limpo", 4'b0010);
    tick(12);
    bus.teclas = 8'h00;
    tick(6);
    chk("limpo_ativo_em_solta", bus.ativo, 1'b1);
    tick(2);
    chk("limpo_ativo_caiu", bus.ativo, 1'b0);
    chk("limpo_codigo_mantido", codigo(), 4'b0010);
    // Bouncy press of note 5.
    for (int i = 0; i < 4; i++) begin
      bus.teclas = (i % 2 == 0) ? 8'b0010_0000 : 8'h00;
      tick(1);
      chk("quique_sem_novo", bus.novo, 1'b0);
    end
    bus.teclas = 8'b0010_0000;
    espera_aceite("quique", 4'b0101);
    solta_tudo();
    // Two keys with tone; extra key while held is ignored.
    bus.teclas = 8'b1001_0000;
    bus.tecla_tom = 1'b1;
    espera_aceite("prioridade", 4'b1100);
    bus.teclas = 8'b1001_0001;
    bus.tecla_tom = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("segura_ignora_novo", bus.novo, 1'b0);
    end
    chk("segura_codigo", codigo(), 4'b1100);
    solta_tudo();
    // Release bounce on note 3.
    bus.teclas = 8'b0000_1000;
    espera_aceite("solta_a", 4'b0011);
    tick(1);
    bus.teclas = 8'h00;
    tick(2);
    bus.teclas = 8'b0000_1000;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("quique_solta_novo", bus.novo, 1'b0);
      chk("quique_solta_ativo", bus.ativo, 1'b1);
    end
    bus.teclas = 8'h00;
    tick(8);
    chk("solta_total_ativo", bus.ativo, 1'b0);
    bus.teclas = 8'b0000_1000;
    espera_aceite("solta_b", 4'b0011);
    solta_tudo();
    // Reset during FILTRO: outputs clear before the next clock edge.
    bus.teclas = 8'b0000_0010;
    tick(4);
    #2 rst_n = 1'b0;
    #1 chk("reset_filtro", {codigo(), bus.novo, bus.ativo}, 6'b0);
    tick(2);
    rst_n = 1'b1;
    espera_aceite("pos_reset_filtro", 4'b0001);
    tick(3);
    #2 rst_n = 1'b0;
    #1 chk("reset_segura", {codigo(), bus.novo, bus.ativo}, 6'b0);
    tick(2);
    rst_n = 1'b1;
    espera_aceite("pos_reset_segura", 4'b0001);
    solta_tudo();
    // Sweep every note with both tone values.
    for (int t = 0; t < 2; t++)
      for (int k = 0; k < 8; k++) begin
        bus.tecla_tom = t[0];
        bus.teclas = 8'(1 << k);
        espera_aceite("varredura", {t[0], k[2:0]});
        solta_tudo();
      end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
